// File: rtl/wa_write_buffer.sv
// Write-side FIFO between the wa strobe interface and a valid/ready memory port.
// Absorbs unthrottled write bursts, presents a registered head entry and counts overflow drops.
module wa_write_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wa_wr_s,
  input  logic [AW-1:0]            wa_addr,
  input  logic [DW-1:0]            wa_data_wr,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [AW+DW-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [LW-1:0]    level_next;
  logic [AW+DW-1:0] head_next;
  logic             push, pop, drop;

  assign pop  = mem_valid & mem_ready;
  assign push = wa_wr_s & (~full | pop);
  assign drop = wa_wr_s & full & ~pop;

  always_comb begin
    rd_next    = pop ? rd_ptr + PW'(1) : rd_ptr;
    level_next = level;
    if (push && !pop)
      level_next = level + LW'(1);
    else if (pop && !push)
      level_next = level - LW'(1);
  end

  // The next head is either an already stored entry or, when the slot being
  // written becomes the head (empty buffer, or single entry popped while pushing),
  // the incoming write itself.
  always_comb begin
    head_next = '0;
    if (level_next != '0) begin
      if (push && (rd_next == wr_ptr))
        head_next = {wa_addr, wa_data_wr};
      else
        head_next = store[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      store[wr_ptr] <= {wa_addr, wa_data_wr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      rd_ptr    <= rd_next;
      level     <= level_next;
      full      <= (level_next == LW'(DEPTH));
      empty     <= (level_next == '0);
      mem_valid <= (level_next != '0);
      {mem_addr, mem_data} <= head_next;
    end
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (clr_ovf)
        drop_cnt <= CNT_W'(1);
      else if (drop_cnt != '1)
        drop_cnt <= drop_cnt + CNT_W'(1);
    end else if (clr_ovf) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_wa_write_buffer.sv
// Directed bench for wa_write_buffer: reset, single write, streaming, fill/stall,
// overflow saturation, push+pop while full and clear/drop collision.
module tb_wa_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wa_wr_s = 1'b0;
  logic [15:0] wa_addr = '0;
  logic [15:0] wa_data_wr = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic [3:0]  level;
  logic        full;
  logic        empty;
  logic        ovf;
  logic [7:0]  drop_cnt;
  logic        clr_ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  wa_write_buffer #(.DEPTH(8), .AW(16), .DW(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .wa_wr_s(wa_wr_s), .wa_addr(wa_addr),
    .wa_data_wr(wa_data_wr), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .level(level), .full(full),
    .empty(empty), .ovf(ovf), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] abase, input logic [15:0] dbase);
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wa_wr_s    = 1'b1;
      wa_addr    = 16'(abase + 16'(i));
      wa_data_wr = 16'(dbase + 16'(i));
      step();
    end
    wa_wr_s = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    checks++; if (empty !== 1'b1 || level !== 4'd0 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle: empty=%b level=%0d valid=%b required 1/0/0", empty, level, mem_valid);
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wa_wr_s = 1'b1; wa_addr = 16'(16'h0100 + 16'(i)); wa_data_wr = 16'h1111; step();
    end
    wa_wr_s = 1'b0;
    checks++; if (level !== 4'd3 || mem_valid !== 1'b1) begin
      errors++; $display("FAIL reset_pre_level: level=%0d valid=%b required 3/1", level, mem_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0 || level !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL reset_async: valid=%b level=%0d empty=%b full=%b required 0/0/1/0", mem_valid, level, empty, full);
    end
    checks++; if (ovf !== 1'b0 || drop_cnt !== 8'd0 || mem_addr !== 16'h0 || mem_data !== 16'h0) begin
      errors++; $display("FAIL reset_outputs: ovf=%b cnt=%0d addr=%h data=%h required 0/0/0000/0000", ovf, drop_cnt, mem_addr, mem_data);
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (mem_valid !== 1'b0 || level !== 4'd0) begin
        errors++; $display("FAIL reset_hold: valid=%b level=%0d required 0/0", mem_valid, level);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (mem_valid !== 1'b0 || empty !== 1'b1 || mem_addr !== 16'h0) begin
        errors++; $display("FAIL reset_no_stale: valid=%b empty=%b addr=%h required 0/1/0000", mem_valid, empty, mem_addr);
      end
    end
  endtask

  task automatic test_single_write();
    mem_ready = 1'b1;
    wa_wr_s = 1'b1; wa_addr = 16'h0010; wa_data_wr = 16'hBEEF;
    #1;
    checks++; if (mem_valid !== 1'b0) begin
      errors++; $display("FAIL single_no_bypass: valid=%b required 0", mem_valid);
    end
    step();
    wa_wr_s = 1'b0;
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 16'h0010 || mem_data !== 16'hBEEF) begin
      errors++; $display("FAIL single_head: valid=%b addr=%h data=%h required 1/0010/beef", mem_valid, mem_addr, mem_data);
    end
    step();
    checks++; if (mem_valid !== 1'b0 || empty !== 1'b1 || mem_addr !== 16'h0 || mem_data !== 16'h0) begin
      errors++; $display("FAIL single_after: valid=%b empty=%b addr=%h data=%h required 0/1/0000/0000", mem_valid, empty, mem_addr, mem_data);
    end
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wa_wr_s = 1'b1; wa_addr = 16'(16'h0300 + 16'(i)); wa_data_wr = 16'(16'h7700 + 16'(i));
      step();
      checks++; if (mem_valid !== 1'b1 || level !== 4'd1 || mem_addr !== 16'(16'h0300 + 16'(i)) || mem_data !== 16'(16'h7700 + 16'(i))) begin
        errors++; $display("FAIL b2b_%0d: valid=%b level=%0d addr=%h data=%h required 1/1/%h/%h", i, mem_valid, level, mem_addr, mem_data, 16'(16'h0300 + 16'(i)), 16'(16'h7700 + 16'(i)));
      end
    end
    wa_wr_s = 1'b0;
    step();
    checks++; if (empty !== 1'b1 || ovf !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL b2b_end: empty=%b ovf=%b cnt=%0d required 1/0/0", empty, ovf, drop_cnt);
    end
  endtask

  task automatic test_fill_stall();
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wa_wr_s = 1'b1; wa_addr = 16'(i); wa_data_wr = 16'(16'hA000 + 16'(i));
      step();
      checks++; if (mem_valid !== 1'b1 || mem_addr !== 16'h0000 || mem_data !== 16'hA000) begin
        errors++; $display("FAIL fill_head_%0d: valid=%b addr=%h data=%h required 1/0000/a000", i, mem_valid, mem_addr, mem_data);
      end
    end
    wa_wr_s = 1'b0;
    checks++; if (full !== 1'b1 || level !== 4'd8 || empty !== 1'b0) begin
      errors++; $display("FAIL fill_full: full=%b level=%0d empty=%b required 1/8/0", full, level, empty);
    end
    repeat (3) step();
    checks++; if (mem_addr !== 16'h0000 || mem_data !== 16'hA000 || mem_valid !== 1'b1) begin
      errors++; $display("FAIL fill_stall_stable: addr=%h data=%h valid=%b required 0000/a000/1", mem_addr, mem_data, mem_valid);
    end
  endtask

  task automatic test_overflow();
    mem_ready = 1'b0;
    for (int k = 0; k < 300; k++) begin
      wa_wr_s = 1'b1; wa_addr = 16'(16'h1000 + 16'(k)); wa_data_wr = 16'hDEAD;
      step();
      if (k == 0) begin
        checks++; if (ovf !== 1'b1 || drop_cnt !== 8'd1) begin
          errors++; $display("FAIL ovf_first: ovf=%b cnt=%0d required 1/1", ovf, drop_cnt);
        end
      end
    end
    wa_wr_s = 1'b0;
    checks++; if (ovf !== 1'b1 || drop_cnt !== 8'd255) begin
      errors++; $display("FAIL ovf_saturate: ovf=%b cnt=%0d required 1/255", ovf, drop_cnt);
    end
    checks++; if (level !== 4'd8 || full !== 1'b1 || mem_addr !== 16'h0000) begin
      errors++; $display("FAIL ovf_level: level=%0d full=%b addr=%h required 8/1/0000", level, full, mem_addr);
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (mem_valid !== 1'b1 || mem_addr !== 16'(i) || mem_data !== 16'(16'hA000 + 16'(i))) begin
        errors++; $display("FAIL drain_%0d: valid=%b addr=%h data=%h required 1/%h/%h", i, mem_valid, mem_addr, mem_data, 16'(i), 16'(16'hA000 + 16'(i)));
      end
      step();
    end
    checks++; if (mem_valid !== 1'b0 || empty !== 1'b1 || level !== 4'd0) begin
      errors++; $display("FAIL drain_end: valid=%b empty=%b level=%0d required 0/1/0", mem_valid, empty, level);
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    checks++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL ovf_clear: ovf=%b cnt=%0d required 0/0", ovf, drop_cnt);
    end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp_addr;
    fill(16'h0020, 16'hC000);
    checks++; if (full !== 1'b1 || level !== 4'd8) begin
      errors++; $display("FAIL fpp_full: full=%b level=%0d required 1/8", full, level);
    end
    mem_ready = 1'b1; wa_wr_s = 1'b1; wa_addr = 16'h00FF; wa_data_wr = 16'h55AA;
    step();
    mem_ready = 1'b0; wa_wr_s = 1'b0;
    checks++; if (level !== 4'd8 || full !== 1'b1 || ovf !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL fpp_nodrop: level=%0d full=%b ovf=%b cnt=%0d required 8/1/0/0", level, full, ovf, drop_cnt);
    end
    checks++; if (mem_addr !== 16'h0021) begin
      errors++; $display("FAIL fpp_head: addr=%h required 0021", mem_addr);
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_addr = (i == 7) ? 16'h00FF : 16'(16'h0021 + 16'(i));
      checks++; if (mem_valid !== 1'b1 || mem_addr !== exp_addr) begin
        errors++; $display("FAIL fpp_drain_%0d: valid=%b addr=%h required 1/%h", i, mem_valid, mem_addr, exp_addr);
      end
      if (i == 7) begin
        checks++; if (mem_data !== 16'h55AA) begin
          errors++; $display("FAIL fpp_last_data: data=%h required 55aa", mem_data);
        end
      end
      step();
    end
    checks++; if (empty !== 1'b1) begin
      errors++; $display("FAIL fpp_end: empty=%b required 1", empty);
    end
  endtask

  task automatic test_clr_collision();
    fill(16'h0040, 16'hE000);
    for (int k = 0; k < 5; k++) begin
      wa_wr_s = 1'b1; wa_addr = 16'h0BAD; wa_data_wr = 16'h0BAD; step();
    end
    wa_wr_s = 1'b0;
    checks++; if (drop_cnt !== 8'd5 || ovf !== 1'b1) begin
      errors++; $display("FAIL coll_pre: cnt=%0d ovf=%b required 5/1", drop_cnt, ovf);
    end
    clr_ovf = 1'b1; wa_wr_s = 1'b1;
    step();
    clr_ovf = 1'b0; wa_wr_s = 1'b0;
    checks++; if (ovf !== 1'b1 || drop_cnt !== 8'd1) begin
      errors++; $display("FAIL coll_drop_wins: ovf=%b cnt=%0d required 1/1", ovf, drop_cnt);
    end
    checks++; if (level !== 4'd8 || mem_addr !== 16'h0040 || mem_data !== 16'hE000) begin
      errors++; $display("FAIL coll_store: level=%0d addr=%h data=%h required 8/0040/e000", level, mem_addr, mem_data);
    end
    mem_ready = 1'b1;
    repeat (8) step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    checks++; if (empty !== 1'b1 || ovf !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL coll_end: empty=%b ovf=%b cnt=%0d required 1/0/0", empty, ovf, drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_fill_stall();
    test_overflow();
    test_full_push_pop();
    test_clr_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
